// File: rtl/sd_block_scheduler.sv
// Fetches num_blocks SD blocks into a circular byte buffer and streams them out one byte at a time.
// Latency: a byte appears on stream_data one cycle after it is written; back-to-back output at 1 byte/cycle.
// Backpressure: stream_ready low holds the output byte; a block is requested only when it fits in the buffer.
module sd_block_scheduler #(
    parameter int BUF_DEPTH   = 1024,
    parameter int BLOCK_BYTES = 512,
    parameter int ADDR_STEP   = 512
) (
    input  logic                         clk_25mhz,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    input  logic [31:0]                  start_addr,
    input  logic [15:0]                  num_blocks,
    output logic                         sd_read_signal,
    output logic [31:0]                  sd_address,
    input  logic [7:0]                   sd_data,
    input  logic                         sd_data_valid,
    input  logic                         sd_done,
    output logic [7:0]                   stream_data,
    output logic                         stream_valid,
    input  logic                         stream_ready,
    output logic                         busy,
    output logic                         finished,
    output logic                         overflow,
    output logic [$clog2(BUF_DEPTH):0]   fill_level
);
    localparam int PW = $clog2(BUF_DEPTH) + 1;
    localparam int AW = PW - 1;
    localparam int CW = $clog2(BLOCK_BYTES) + 1;

    typedef enum logic [2:0] {IDLE, WAIT_SPACE, ISSUE, READING, DRAIN, ABORT} state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [15:0]     blk_rem_q, blk_rem_d;
    logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
    logic            ovf_q, ovf_d;
    logic            fin_q, fin_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            out_vld_q, out_vld_d;
    logic [7:0]      out_dat_q, out_dat_d;
    logic            dv_prev_q, done_prev_q;

    logic [7:0]      mem [BUF_DEPTH];

    logic            dv_rise, done_rise, xfer, flush, wr_en, space_ok;
    logic [PW-1:0]   fill_lvl, rd_nxt;

    assign dv_rise   = sd_data_valid & ~dv_prev_q;
    assign done_rise = sd_done & ~done_prev_q;
    assign fill_lvl  = wr_ptr_q - rd_ptr_q;
    assign space_ok  = fill_lvl <= PW'(BUF_DEPTH - BLOCK_BYTES);
    assign xfer      = out_vld_q & stream_ready;
    assign rd_nxt    = rd_ptr_q + PW'(xfer);

    assign sd_read_signal = (state_q == ISSUE) && !stop;
    assign sd_address     = addr_q;
    assign stream_data    = out_dat_q;
    assign stream_valid   = out_vld_q;
    assign busy           = (state_q != IDLE);
    assign finished       = fin_q;
    assign overflow       = ovf_q;
    assign fill_level     = fill_lvl;

    // Control FSM: block sequencing, per-block byte accounting, abort and completion.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        blk_rem_d  = blk_rem_q;
        byte_cnt_d = byte_cnt_q;
        ovf_d      = ovf_q;
        fin_d      = 1'b0;
        flush      = 1'b0;
        wr_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_blocks != 16'd0) begin
                        addr_d    = start_addr;
                        blk_rem_d = num_blocks;
                        ovf_d     = 1'b0;
                        state_d   = WAIT_SPACE;
                    end else begin
                        fin_d = 1'b1;
                    end
                end
            end
            WAIT_SPACE: begin
                if (stop) begin
                    flush = 1'b1; fin_d = 1'b1; state_d = IDLE;
                end else if (space_ok) begin
                    byte_cnt_d = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (stop) begin
                    flush = 1'b1; fin_d = 1'b1; state_d = IDLE;
                end else begin
                    state_d = READING;
                end
            end
            READING: begin
                if (dv_rise) begin
                    if (byte_cnt_q == CW'(BLOCK_BYTES)) begin
                        ovf_d = 1'b1;                       // strobe beyond a full block
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        if (fill_lvl == PW'(BUF_DEPTH)) ovf_d = 1'b1;
                        else                            wr_en = 1'b1;
                    end
                end
                if (done_rise) begin
                    if (byte_cnt_d != CW'(BLOCK_BYTES)) ovf_d = 1'b1;   // short block
                    addr_d    = addr_q + 32'(ADDR_STEP);
                    blk_rem_d = blk_rem_q - 16'd1;
                    if (stop) begin
                        flush = 1'b1; fin_d = 1'b1; state_d = IDLE;
                    end else if (blk_rem_q == 16'd1) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = WAIT_SPACE;
                    end
                end else if (stop) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                // the reader cannot be cancelled mid-block: swallow bytes until it signals done
                if (done_rise) begin
                    flush = 1'b1; fin_d = 1'b1; state_d = IDLE;
                end
            end
            DRAIN: begin
                if (stop) begin
                    flush = 1'b1; fin_d = 1'b1; state_d = IDLE;
                end else if (fill_lvl == '0 && !out_vld_q) begin
                    fin_d = 1'b1; state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer pointers and the FWFT output register; rd_ptr only advances on a consumer transfer,
    // so the byte held in the output register still counts toward fill_level.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + PW'(wr_en);
        rd_ptr_d  = rd_nxt;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        if (flush) begin
            rd_ptr_d  = wr_ptr_d;
            out_vld_d = 1'b0;
        end else if (!out_vld_q || xfer) begin
            if (wr_ptr_q != rd_nxt) begin
                out_vld_d = 1'b1;
                out_dat_d = mem[rd_nxt[AW-1:0]];
            end else begin
                out_vld_d = 1'b0;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            blk_rem_q   <= '0;
            byte_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            fin_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_vld_q   <= 1'b0;
            out_dat_q   <= '0;
            dv_prev_q   <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            blk_rem_q   <= blk_rem_d;
            byte_cnt_q  <= byte_cnt_d;
            ovf_q       <= ovf_d;
            fin_q       <= fin_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_vld_q   <= out_vld_d;
            out_dat_q   <= out_dat_d;
            dv_prev_q   <= sd_data_valid;
            done_prev_q <= sd_done;
        end
    end

    // Buffer storage; contents need no reset since the pointers define what is valid.
    always_ff @(posedge clk_25mhz) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= sd_data;
    end

endmodule
